// File: rtl/sca_pkg.sv
// sca_pkg: shared FSM encoding, default geometry and counter-width helper for the SCA readout receiver.
package sca_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} sca_state_t;
    localparam int SCA_WORD_W    = 12;
    localparam int SCA_NUM_CELLS = 64;
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
    localparam int SCA_BIT_CNT_W  = cnt_w(SCA_WORD_W + 1);
    localparam int SCA_WORD_CNT_W = cnt_w(SCA_NUM_CELLS);
endpackage

// File: rtl/sca_readout_rx_if.sv
// sca_readout_rx_if: valid/ready cell-word stream with end-of-frame and parity-error flags.
interface sca_readout_rx_if
    import sca_pkg::*;
#(
    parameter int WORD_W = SCA_WORD_W
);
    logic [WORD_W-1:0] data;
    logic last, perr, valid, ready;
    modport master(output data, last, perr, valid, input ready);
    modport slave(input data, last, perr, valid, output ready);
endinterface

// File: rtl/sca_rx_fifo.sv
// sca_rx_fifo: synchronous show-ahead FIFO; a push into a full FIFO succeeds only alongside a pop.
module sca_rx_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/sca_readout_rx.sv
// sca_readout_rx: deserialises SCA DFF output into cell words, buffers and streams them.
// Define SCA_RX_PARITY_EN to receive a trailing even-parity bit per word and flag errors on perr.
module sca_readout_rx
    import sca_pkg::*;
#(
    parameter int WORD_W     = SCA_WORD_W,
    parameter int NUM_CELLS  = SCA_NUM_CELLS,
    parameter int SAMPLE_DLY = 4,
    parameter int TIMEOUT    = 2047,
    parameter int FIFO_DEPTH = 16
) (
    input  logic clk_125,
    input  logic rst,
    input  logic arm,
    input  logic clk_dff_in,
    input  logic sdata_in,
    sca_readout_rx_if.master out,
    output logic busy,
    output logic frame_done,
    output logic overflow,
    output logic proto_err
);
`ifdef SCA_RX_PARITY_EN
    localparam int BPW = WORD_W + 1;
`else
    localparam int BPW = WORD_W;
`endif
    localparam int BCW = cnt_w(BPW);
    localparam int WCW = cnt_w(NUM_CELLS);
    localparam int DCW = cnt_w(SAMPLE_DLY + 1);
    localparam int TCW = cnt_w(TIMEOUT);
    sca_state_t state_q, state_d;
    logic clk_dff_q, sdata_sync1, sdata_sync2;
    logic [DCW-1:0] dly_cnt;
    logic [BCW-1:0] bit_cnt;
    logic [WCW-1:0] word_cnt;
    logic [TCW-1:0] wd_cnt;
    logic [BPW-1:0] shreg;
    logic [WORD_W-1:0] word;
    logic [WORD_W+1:0] dout;
    logic push_pend, rise, sample, word_end, timeout, is_last, perr, full, empty, pop;
`ifdef SCA_RX_PARITY_EN
    assign word = shreg[BPW-1:1];
    assign perr = ^shreg;
`else
    assign word = shreg;
    assign perr = 1'b0;
`endif
    assign busy       = state_q != IDLE;
    assign rise       = clk_dff_in & ~clk_dff_q;
    // A rise landing on the sample cycle still wins: the pending sample is dropped
    assign sample     = dly_cnt == DCW'(1) && !rise;
    assign word_end   = sample && bit_cnt == BCW'(BPW - 1);
    assign timeout    = busy && !rise && wd_cnt == TCW'(TIMEOUT - 1);
    assign is_last    = word_cnt == WCW'(NUM_CELLS - 1);
    assign frame_done = push_pend & is_last;
    assign pop        = out.valid & out.ready;
    assign out.valid  = ~empty;
    assign {out.data, out.last, out.perr} = empty ? '0 : dout;
    sca_rx_fifo #(.W(WORD_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk_125), .rst(rst), .push(push_pend), .pop(pop),
        .din({word, is_last, perr}), .dout(dout), .full(full), .empty(empty)
    );
    always_ff @(posedge clk_125 or posedge rst)
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = arm ? ARMED : IDLE;
        else if (timeout || (state_q == SHIFT && push_pend && is_last)) state_d = IDLE;
        else if (state_q == ARMED && rise) state_d = SHIFT;
    end
    always_ff @(posedge clk_125 or posedge rst) begin
        if (rst) begin
            clk_dff_q   <= 1'b0;
            sdata_sync1 <= 1'b0;
            sdata_sync2 <= 1'b0;
            dly_cnt     <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            wd_cnt      <= '0;
            shreg       <= '0;
            push_pend   <= 1'b0;
            overflow    <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            clk_dff_q   <= clk_dff_in;
            sdata_sync1 <= sdata_in;
            sdata_sync2 <= sdata_sync1;
            push_pend   <= word_end;
            wd_cnt      <= (!busy || rise) ? '0 : wd_cnt + 1'b1;
            dly_cnt     <= (!busy || timeout) ? '0 : rise ? DCW'(SAMPLE_DLY) :
                           (dly_cnt != '0) ? dly_cnt - 1'b1 : dly_cnt;
            if (sample) shreg <= {shreg[BPW-2:0], sdata_sync2};
            if (sample || timeout) bit_cnt <= (word_end || timeout) ? '0 : bit_cnt + 1'b1;
            if (push_pend) word_cnt <= word_cnt + 1'b1;
            if (push_pend && full && !pop) overflow <= 1'b1;
            if ((rise && dly_cnt != '0) || timeout) proto_err <= 1'b1;
            if (!busy && arm) begin
                bit_cnt   <= '0;
                word_cnt  <= '0;
                overflow  <= 1'b0;
                proto_err <= 1'b0;
            end
        end
    end
endmodule
